// File: rtl/demux3_8_buf.sv
// Buffered 1-to-8 distributor: routes each accepted word into one of eight
// single-entry slots, each drained by its own independent valid/ready sink.
module demux3_8_buf #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [3:0]         occupancy
);

    logic [WIDTH-1:0] data_q [8];
    logic [7:0]       full_q;
    logic [3:0]       occupancy_q;

    logic             accept;
    logic [7:0]       accept_vec;
    logic [7:0]       drain_vec;
    logic [7:0]       full_d;
    logic [3:0]       occupancy_d;
    logic [3:0]       drain_count;
    logic             fill_empty;

    // A full slot can still take a word when its sink drains on the same edge.
    assign in_ready   = ~full_q[in_sel] | out_ready[in_sel];
    assign accept     = in_valid & in_ready;
    assign accept_vec = accept ? (8'd1 << in_sel) : 8'd0;
    assign drain_vec  = full_q & out_ready;
    assign full_d     = (full_q & ~drain_vec) | accept_vec;
    assign fill_empty = accept & ~full_q[in_sel];

    always_comb begin
        drain_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (drain_vec[i] && !accept_vec[i]) begin
                drain_count = drain_count + 4'd1;
            end
        end
        occupancy_d = occupancy_q + {3'd0, fill_empty} - drain_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 8'd0;
            occupancy_q <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            occupancy_q <= occupancy_d;
            for (int i = 0; i < 8; i++) begin
                if (accept_vec[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 8; i++) begin
            out_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign out_valid = full_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_demux3_8_buf.sv
// Directed and scoreboard-checked bench for demux3_8_buf: reset, routing,
// stall/refill, streaming, multi-drain, async reset and ordered delivery.
module tb_demux3_8_buf;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic [31:0]  in_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [255:0] out_data;
    logic [3:0]   occupancy;

    int test_count = 0;
    int fail_count = 0;

    demux3_8_buf #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = 32'd0;
        out_ready = 8'd0;
        #12;
        test_count++;
        if (out_valid !== 8'h00) begin
            fail_count++;
            $display("[TB] FAIL reset_out_valid got %h want 00", out_valid);
        end
        test_count++;
        if (occupancy !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy);
        end
        test_count++;
        if (out_data !== 256'd0) begin
            fail_count++;
            $display("[TB] FAIL reset_out_data got %h want 0", out_data);
        end
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            test_count++;
            if (in_ready !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
            end
        end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 32'hDEADBEEF;
        out_ready = 8'h00;
        tick();
        in_valid = 1'b0;
        in_data  = 32'd0;
        #1;
        test_count++;
        if (out_valid !== 8'h08) begin
            fail_count++;
            $display("[TB] FAIL single_out_valid got %h want 08", out_valid);
        end
        test_count++;
        if (out_data[3*32 +: 32] !== 32'hDEADBEEF) begin
            fail_count++;
            $display("[TB] FAIL single_slot3 got %h want deadbeef", out_data[3*32 +: 32]);
        end
        test_count++;
        if (occupancy !== 4'd1) begin
            fail_count++;
            $display("[TB] FAIL single_occupancy got %0d want 1", occupancy);
        end
        test_count++;
        if (in_ready !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL single_in_ready_sel3 got %b want 0", in_ready);
        end
        in_sel = 3'd0;
        #1;
        test_count++;
        if (in_ready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL single_in_ready_sel0 got %b want 1", in_ready);
        end
        // Drain slot 3 so the next scenario starts empty.
        out_ready = 8'h08;
        tick();
        out_ready = 8'h00;
        #1;
        test_count++;
        if (occupancy !== 4'd0 || out_valid !== 8'h00) begin
            fail_count++;
            $display("[TB] FAIL single_drain got occ=%0d valid=%h want occ=0 valid=00", occupancy, out_valid);
        end
    endtask

    task automatic test_stall_release();
        in_valid = 1'b1;
        in_sel   = 3'd5;
        in_data  = 32'h55550001;
        tick();
        in_data = 32'h55550002;
        for (int c = 0; c < 3; c++) begin
            #1;
            test_count++;
            if (in_ready !== 1'b0) begin
                fail_count++;
                $display("[TB] FAIL stall_in_ready cycle=%0d got %b want 0", c, in_ready);
            end
            tick();
            test_count++;
            if (out_data[5*32 +: 32] !== 32'h55550001 || out_valid !== 8'h20) begin
                fail_count++;
                $display("[TB] FAIL stall_hold cycle=%0d got slot5=%h valid=%h want 55550001 valid=20",
                         c, out_data[5*32 +: 32], out_valid);
            end
        end
        out_ready = 8'h20;
        #1;
        test_count++;
        if (in_ready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL release_in_ready got %b want 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        test_count++;
        if (out_data[5*32 +: 32] !== 32'h55550002 || out_valid !== 8'h20) begin
            fail_count++;
            $display("[TB] FAIL release_refill got slot5=%h valid=%h want 55550002 valid=20",
                     out_data[5*32 +: 32], out_valid);
        end
        test_count++;
        if (occupancy !== 4'd1) begin
            fail_count++;
            $display("[TB] FAIL release_occupancy got %0d want 1", occupancy);
        end
        out_ready = 8'h20;
        tick();
        out_ready = 8'h00;
        #1;
        test_count++;
        if (out_valid !== 8'h00 || out_data[5*32 +: 32] !== 32'h55550002 || occupancy !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL drain_keeps_data got valid=%h slot5=%h occ=%0d want 00 55550002 0",
                     out_valid, out_data[5*32 +: 32], occupancy);
        end
    endtask

    task automatic test_streaming();
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_sel   = 3'(s);
            in_data  = 32'(s + 1);
            #1;
            test_count++;
            if (in_ready !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL stream_in_ready sel=%0d got %b want 1", s, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        test_count++;
        if (out_valid !== 8'hFF) begin
            fail_count++;
            $display("[TB] FAIL stream_out_valid got %h want ff", out_valid);
        end
        test_count++;
        if (occupancy !== 4'd8) begin
            fail_count++;
            $display("[TB] FAIL stream_occupancy got %0d want 8", occupancy);
        end
        for (int s = 0; s < 8; s++) begin
            test_count++;
            if (out_data[s*32 +: 32] !== 32'(s + 1)) begin
                fail_count++;
                $display("[TB] FAIL stream_slot%0d got %h want %h", s, out_data[s*32 +: 32], s + 1);
            end
        end
    endtask

    task automatic test_multi_drain();
        out_ready = 8'hA5;
        tick();
        out_ready = 8'h00;
        #1;
        test_count++;
        if (out_valid !== 8'h5A) begin
            fail_count++;
            $display("[TB] FAIL multi_out_valid got %h want 5a", out_valid);
        end
        test_count++;
        if (occupancy !== 4'd4) begin
            fail_count++;
            $display("[TB] FAIL multi_occupancy got %0d want 4", occupancy);
        end
    endtask

    task automatic test_ignored_inputs();
        // in_valid low with a free slot selected, plus a ready on an empty slot.
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = 32'hCAFEF00D;
        out_ready = 8'h01;
        tick();
        out_ready = 8'h00;
        #1;
        test_count++;
        if (out_valid !== 8'h5A || occupancy !== 4'd4 || out_data[31:0] !== 32'd1) begin
            fail_count++;
            $display("[TB] FAIL ignored_inputs got valid=%h occ=%0d slot0=%h want 5a 4 00000001",
                     out_valid, occupancy, out_data[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 8'h01;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h100 + 32'(k);
            #1;
            test_count++;
            if (in_ready !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL b2b_in_ready k=%0d got %b want 1", k, in_ready);
            end
            tick();
            test_count++;
            if (out_data[31:0] !== 32'h100 + 32'(k) || out_valid !== 8'h5B || occupancy !== 4'd5) begin
                fail_count++;
                $display("[TB] FAIL b2b_word k=%0d got slot0=%h valid=%h occ=%0d want %h 5b 5",
                         k, out_data[31:0], out_valid, occupancy, 32'h100 + k);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 8'h00;
        #1;
        test_count++;
        if (out_valid !== 8'h5A || occupancy !== 4'd4) begin
            fail_count++;
            $display("[TB] FAIL b2b_final_drain got valid=%h occ=%0d want 5a 4", out_valid, occupancy);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        test_count++;
        if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL async_reset got valid=%h occ=%0d want 00 0", out_valid, occupancy);
        end
        #1;
        rst_n = 1'b1;
        #1;
        test_count++;
        if (out_data !== 256'd0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_data got %h want 0", out_data);
        end
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #0.1;
            test_count++;
            if (in_ready !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL async_reset_in_ready sel=%0d got %b want 1", s, in_ready);
            end
        end
        tick();
    endtask

    task automatic test_random_order();
        logic        mfull [8];
        logic [31:0] mdata [8];
        logic        exp_ready;
        int          accepted = 0;
        int          drained = 0;
        int          mcount;
        for (int s = 0; s < 8; s++) begin
            mfull[s] = 1'b0;
            mdata[s] = 32'd0;
        end
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            out_ready = 8'($urandom) & 8'($urandom);
            #1;
            mcount = 0;
            for (int s = 0; s < 8; s++) begin
                if (mfull[s]) mcount++;
                test_count++;
                if (out_valid[s] !== mfull[s] || (mfull[s] && out_data[s*32 +: 32] !== mdata[s])) begin
                    fail_count++;
                    $display("[TB] FAIL rand_slot c=%0d slot=%0d got v=%b d=%h want v=%b d=%h",
                             c, s, out_valid[s], out_data[s*32 +: 32], mfull[s], mdata[s]);
                end
            end
            test_count++;
            if (occupancy !== 4'(mcount) || occupancy !== 4'($countones(out_valid))) begin
                fail_count++;
                $display("[TB] FAIL rand_occupancy c=%0d got %0d want %0d", c, occupancy, mcount);
            end
            exp_ready = !mfull[in_sel] || out_ready[in_sel];
            test_count++;
            if (in_ready !== exp_ready) begin
                fail_count++;
                $display("[TB] FAIL rand_in_ready c=%0d got %b want %b", c, in_ready, exp_ready);
            end
            for (int s = 0; s < 8; s++) begin
                if (mfull[s] && out_ready[s]) begin
                    mfull[s] = 1'b0;
                    drained++;
                end
            end
            if (in_valid && exp_ready) begin
                mfull[in_sel] = 1'b1;
                mdata[in_sel] = in_data;
                accepted++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        test_count++;
        if (32'(occupancy) !== 32'(accepted - drained)) begin
            fail_count++;
            $display("[TB] FAIL rand_conservation got occ=%0d want %0d", occupancy, accepted - drained);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall_release();
        test_streaming();
        test_multi_drain();
        test_ignored_inputs();
        test_back_to_back();
        test_async_reset();
        test_random_order();
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
